// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command engine.
// Holds the opcode encodings, the frame FSM state type and the result
// value returned for unknown opcodes.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  localparam logic [DATA_W-1:0] OP_ADD = 8'h00;
  localparam logic [DATA_W-1:0] OP_SUB = 8'h01;
  localparam logic [DATA_W-1:0] OP_AND = 8'h02;
  localparam logic [DATA_W-1:0] OP_OR  = 8'h03;
  localparam logic [DATA_W-1:0] OP_XOR = 8'h04;
  localparam logic [DATA_W-1:0] OP_MUL = 8'h05;

  localparam logic [RES_W-1:0] RES_ERR = 16'hFFFF;

  typedef enum logic [2:0] {
    S_OP,
    S_A,
    S_B,
    S_EX,
    S_HI,
    S_LO
  } state_t;

endpackage

// File: rtl/alu_cmd_engine_if.sv
// Byte-stream bus between the receive skid buffer, the command engine and
// the TX path.
//   data_i/valid_in/ready_in     : inbound bytes (opcode, A, B)
//   data_o/valid_out/ready_out   : outbound result bytes (high byte first)
//   err_o                        : pulse, evaluated frame had unknown opcode
//   timeout_o                    : pulse, partial frame discarded
// Modport slave is the engine side, master is the environment side.
interface alu_cmd_engine_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] data_i;
  logic              valid_in;
  logic              ready_in;
  logic [DATA_W-1:0] data_o;
  logic              valid_out;
  logic              ready_out;
  logic              err_o;
  logic              timeout_o;

  modport slave (
    input  data_i, valid_in, ready_out,
    output ready_in, data_o, valid_out, err_o, timeout_o
  );

  modport master (
    output data_i, valid_in, ready_out,
    input  ready_in, data_o, valid_out, err_o, timeout_o
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU evaluating one command frame.
// Ports:
//   op       : opcode byte
//   a, b     : unsigned operands
//   res      : 16-bit result (RES_ERR for unknown opcodes)
//   op_valid : 1 when op is a known opcode
module alu_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [RES_W-1:0]  res,
  output logic              op_valid
);

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  // Operands are widened first so ADD keeps its carry, SUB wraps mod 2^16
  // and MUL keeps the full product.
  assign a_ext = {8'h00, a};
  assign b_ext = {8'h00, b};

  always_comb begin
    res      = RES_ERR;
    op_valid = 1'b1;
    case (op)
      OP_ADD:  res = a_ext + b_ext;
      OP_SUB:  res = a_ext - b_ext;
      OP_AND:  res = {8'h00, a & b};
      OP_OR:   res = {8'h00, a | b};
      OP_XOR:  res = {8'h00, a ^ b};
      OP_MUL:  res = a_ext * b_ext;
      default: begin
        res      = RES_ERR;
        op_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_cmd_engine.sv
// Command engine: assembles 3-byte frames (opcode, A, B) from the inbound
// byte stream, evaluates them with alu_core and returns a 2-byte result,
// high byte first. A partial frame left idle for TIMEOUT_CYC cycles is
// dropped so a lost byte cannot misalign framing permanently.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : alu_cmd_engine_if slave (in/out byte streams, err/timeout pulses)
module alu_cmd_engine
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_cmd_engine_if.slave       bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;
  logic              tmo_q;

  logic [DATA_W-1:0] op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [RES_W-1:0]  res_q;

  logic [RES_W-1:0]  core_res;
  logic              core_ok;
  logic              hs_in;
  logic              hs_out;

  alu_core u_core (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .res      (core_res),
    .op_valid (core_ok)
  );

  // ready_in is a decode of the registered state; rst only masks it so no
  // byte is taken during the reset cycle.
  assign bus.ready_in  = ~rst & ((state == S_OP) | (state == S_A) | (state == S_B));
  assign bus.valid_out = (state == S_HI) | (state == S_LO);
  assign bus.err_o     = err_q;
  assign bus.timeout_o = tmo_q;

  assign hs_in  = bus.valid_in & bus.ready_in;
  assign hs_out = bus.valid_out & bus.ready_out;

  always_comb begin
    bus.data_o = 8'h00;
    if (state == S_HI)      bus.data_o = res_q[15:8];
    else if (state == S_LO) bus.data_o = res_q[7:0];
  end

  // Control: frame FSM, inter-byte timeout counter, status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_OP;
      cnt   <= '0;
      err_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      tmo_q <= 1'b0;
      case (state)
        S_OP: begin
          cnt <= '0;
          if (hs_in) state <= S_A;
        end
        S_A, S_B: begin
          // An accepted byte always wins over a timeout firing this cycle.
          if (hs_in) begin
            cnt   <= '0;
            state <= (state == S_A) ? S_B : S_EX;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_OP;
            tmo_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EX: begin
          cnt   <= '0;
          err_q <= ~core_ok;
          state <= S_HI;
        end
        S_HI: begin
          cnt <= '0;
          if (hs_out) state <= S_LO;
        end
        S_LO: begin
          cnt <= '0;
          if (hs_out) state <= S_OP;
        end
        default: begin
          cnt   <= '0;
          state <= S_OP;
        end
      endcase
    end
  end

  // Datapath: operand capture and result register, qualified by state only.
  always_ff @(posedge clk) begin
    if (hs_in && state == S_OP) op_q <= bus.data_i;
    if (hs_in && state == S_A)  a_q  <= bus.data_i;
    if (hs_in && state == S_B)  b_q  <= bus.data_i;
    if (state == S_EX)          res_q <= core_res;
  end

endmodule

// File: tb/tb_alu_cmd_engine.sv
// Scoreboard bench for alu_cmd_engine (TIMEOUT_CYC = 16).
// Stimulus pushes expected result bytes; a negedge monitor pops and
// compares on every output handshake and counts err/timeout pulses.
module tb_alu_cmd_engine;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_engine_if bus ();

  alu_cmd_engine #(.TIMEOUT_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int tmo_seen = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid_out && bus.ready_out) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %h expected none", bus.data_o);
        end else begin
          chk("out_byte", {8'h00, bus.data_o}, {8'h00, exp_q.pop_front()});
        end
      end
      if (bus.err_o) err_seen++;
      if (bus.timeout_o) tmo_seen++;
      if (bus.err_o && bus.timeout_o) chk("err_and_timeout", 16'd1, 16'd0);
    end
  end

  // Called right after a posedge (+#1); returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.data_i   = b;
    bus.valid_in = 1'b1;
    @(negedge clk);
    while (!bus.ready_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_in) chk("send_ready_timeout", 16'd0, 16'd1);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    bus.data_i   = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [15:0] exp);
    exp_q.push_back(exp[15:8]);
    exp_q.push_back(exp[7:0]);
    send_byte(op);
    send_byte(a);
    send_byte(b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 16'(exp_q.size()), 16'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int e0;
    int t0;
    bus.data_i    = 8'h00;
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_in",  {15'd0, bus.ready_in},  16'd0);
    chk("rst_valid_out", {15'd0, bus.valid_out}, 16'd0);
    chk("rst_data_o",    {8'd0, bus.data_o},     16'd0);
    chk("rst_err",       {15'd0, bus.err_o},     16'd0);
    chk("rst_timeout",   {15'd0, bus.timeout_o}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // MUL 12*11 = 132 with latency check
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h84);
    send_byte(8'h05);
    send_byte(8'h0C);
    send_byte(8'h0B);
    @(negedge clk);
    chk("lat_ex_valid", {15'd0, bus.valid_out}, 16'd0);
    @(negedge clk);
    chk("lat_hi_valid", {15'd0, bus.valid_out}, 16'd1);
    @(posedge clk); #1;
    drain();
    chk("mul_no_err", 16'(err_seen), 16'd0);

    // SUB 3-5 under backpressure
    bus.ready_out = 1'b0;
    send_frame(8'h01, 8'h03, 8'h05, 16'hFFFE);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid",    {15'd0, bus.valid_out}, 16'd1);
      chk("bp_data",     {8'd0, bus.data_o},     16'h00FF);
      chk("bp_ready_in", {15'd0, bus.ready_in},  16'd0);
    end
    @(posedge clk); #1;
    bus.ready_out = 1'b1;
    drain();

    // Unknown opcode, then ADD max
    e0 = err_seen;
    send_frame(8'h09, 8'h12, 8'h34, 16'hFFFF);
    drain();
    chk("bad_op_err_pulse", 16'(err_seen - e0), 16'd1);
    send_frame(8'h00, 8'hFF, 8'hFF, 16'h01FE);
    drain();
    chk("add_no_err", 16'(err_seen - e0), 16'd1);

    // Timeout in S_B after 16 idle cycles
    t0 = tmo_seen;
    send_byte(8'h00);
    send_byte(8'h10);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("tmo_not_early", {15'd0, bus.timeout_o}, 16'd0);
    @(negedge clk);
    chk("tmo_pulse", {15'd0, bus.timeout_o}, 16'd1);
    @(negedge clk);
    chk("tmo_one_cycle", {15'd0, bus.timeout_o}, 16'd0);
    chk("tmo_count", 16'(tmo_seen - t0), 16'd1);
    @(posedge clk); #1;
    send_frame(8'h02, 8'hF0, 8'h3C, 16'h0030);
    drain();

    // B arrives on the exact cycle the counter reaches 15
    t0 = tmo_seen;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h33);
    send_byte(8'h00);
    send_byte(8'h11);
    repeat (15) @(posedge clk);
    #1;
    send_byte(8'h22);
    drain();
    chk("race_no_timeout", 16'(tmo_seen - t0), 16'd0);

    // Reset while presenting the high byte
    bus.ready_out = 1'b0;
    send_byte(8'h05);
    send_byte(8'h10);
    send_byte(8'h10);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", {15'd0, bus.valid_out}, 16'd1);
    chk("pre_rst_data",  {8'd0, bus.data_o},     16'h0001);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {15'd0, bus.valid_out}, 16'd0);
    chk("post_rst_data",  {8'd0, bus.data_o},     16'h0000);
    @(posedge clk); #1;
    bus.ready_out = 1'b1;
    send_frame(8'h04, 8'hAA, 8'h0F, 16'h00A5);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
